cache_bus_unit: RTL
===================

Name: cache_bus_unit

Overview:
- Responder end of the L1 cache-bus protocol; sits between each per-hart L1 and the shared memory bus.
- Accepts write-through, single-read and line-fill requests and sequences them as single-beat memory transactions.
- Returns beat data, beat index, line/entry write strobes, completion and error to the L1.

Parameters:
LINE_BEATS, 8, doublewords (64-bit) per cache line; power of two, 2..1024
TIMEOUT_CYCLES, 1023, watchdog limit in cycles; used only with CBU_TIMEOUT_EN

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
L1_write_through_req  input  1  write-through request, level, held until trans_rdy
read_req  input  1  single uncached read request, level
read_line_req  input  1  line-fill request, level
L1_size  input  4  0001=1B 0010=2B 0100=4B 1000=8B
pa  input  64  physical address
wt_data  input  64  write data
line_data  output  64  read data (beat data or single-read result)
addr_count  output  11  beat index within current line
line_write  output  1  one-cycle strobe: line_data/addr_count valid for L1 array write
cache_entry_write  output  1  one-cycle strobe: line complete, update tag/valid
trans_rdy  output  1  one-cycle completion strobe
bus_error  output  1  one-cycle error strobe, coincident with trans_rdy
mem_req  output  1  memory bus request, held until mem_ack or mem_err
mem_we  output  1  1=write
mem_addr  output  64  memory address
mem_wdata  output  64  memory write data
mem_size  output  4  same encoding as L1_size
mem_ack  input  1  beat complete; mem_rdata valid this cycle
mem_rdata  input  64  memory read data
mem_err  input  1  beat failed

Behaviour:
- Reset: all outputs 0; state IDLE; beat counter 0.
- States: IDLE, WT, RD, LINE, DONE, HOLD.
- IDLE: sample requests.
  - Priority: L1_write_through_req > read_line_req > read_req.
  - Latch pa, wt_data and L1_size into internal registers.
  - Next state WT, LINE or RD; mem_req asserts the following cycle.
- WT:
  - mem_we=1, mem_addr=pa, mem_wdata=wt_data, mem_size=L1_size.
  - On mem_ack, go to DONE.
- RD:
  - mem_we=0, mem_addr=pa, mem_size=L1_size.
  - On mem_ack, register line_data=mem_rdata and go to DONE.
- LINE:
  - mem_we=0, mem_size=1000.
  - mem_addr = {pa[63:log2(LINE_BEATS)+3] aligned down, beat, 3'b000}.
  - Per mem_ack: next cycle line_write=1, line_data=mem_rdata, addr_count=beat; then increment beat.
  - mem_req deasserts for exactly one cycle between beats.
  - After the last beat (beat=LINE_BEATS-1) is acked, go to DONE with entry=1.
- DONE:
  - trans_rdy=1 for one cycle.
  - cache_entry_write=1 in the same cycle for a successful line fill only.
  - line_data keeps its value until the next request is accepted.
  - The final line_write occurs in the cycle before DONE.
- HOLD:
  - One cycle with requests ignored, so the L1 can drop its level request; then IDLE.
  - Minimum spacing: trans_rdy to the next mem_req is 3 cycles.
- mem_err in any active state:
  - Abort immediately, drop mem_req.
  - Next cycle: trans_rdy=1 and bus_error=1; no cache_entry_write; no further line_write for that line.
  - Then HOLD.
- mem_ack and mem_err together: treat as error.
- Requests that change or drop mid-transaction are ignored; latched values are used.
- rst mid-transaction: immediate return to IDLE, all strobes cleared, mem_req drops next edge. The memory side must tolerate the abandoned request.
- addr_count is zero-extended beat index; upper bits 0 when LINE_BEATS<2048.

Optional Feature:
- Macro CBU_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on every mem_req rising edge and counts while mem_req=1 without ack/err.
  - When the counter reaches TIMEOUT_CYCLES, the beat is aborted exactly as mem_err: trans_rdy+bus_error next cycle.
- Undefined:
  - No counter; the unit waits indefinitely for mem_ack/mem_err.

Test Plan:
- Write-through: pa=0x8000_0010, wt_data=0x1122334455667788, L1_size=0100, ack after 2 cycles -> mem_we=1, mem_addr=0x8000_0010, mem_size=0100; one trans_rdy; bus_error=0; no line_write.
- Single read: read_req, pa=0x1000_0008, mem_rdata=0xDEADBEEF_CAFEF00D -> line_data equals that value at trans_rdy; no line_write or cache_entry_write.
- Line fill, LINE_BEATS=8, pa=0x8000_0128:
  - mem_addr steps 0x8000_0100..0x8000_0138 by 8.
  - 8 line_write strobes with addr_count 0..7 carrying beat data.
  - cache_entry_write and trans_rdy coincident, one cycle after the last line_write.
- Error mid-line: mem_err on beat 3 -> exactly 3 line_write strobes (0..2); trans_rdy+bus_error together; cache_entry_write never; next request accepted after HOLD.
- Priority/simultaneous: all three requests asserted together -> write-through served first; with only read_line_req and read_req still held, the line fill is served next after HOLD.
- Reset mid-line fill at beat 4 -> all outputs 0 the cycle after rst; state IDLE; a subsequent read_req completes normally.
- (CBU_TIMEOUT_EN, TIMEOUT_CYCLES=15) mem_ack never arrives -> bus_error+trans_rdy 16 cycles after mem_req rises.

Source files
------------

// File: rtl/cache_bus_unit.sv
// rtl/cache_bus_unit.sv - L1 cache-bus responder sequencing single-beat memory transactions
// Optional beat watchdog enabled by defining CBU_TIMEOUT_EN.
module cache_bus_unit #(
  parameter int LINE_BEATS     = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        L1_write_through_req,
  input  logic        read_req,
  input  logic        read_line_req,
  input  logic [3:0]  L1_size,
  input  logic [63:0] pa,
  input  logic [63:0] wt_data,
  output logic [63:0] line_data,
  output logic [10:0] addr_count,
  output logic        line_write,
  output logic        cache_entry_write,
  output logic        trans_rdy,
  output logic        bus_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [3:0]  mem_size,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  input  logic        mem_err
);
  localparam int BW = $clog2(LINE_BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_BEATS - 1);

  typedef enum logic [2:0] {IDLE, WT, RD, LINE, DONE, HOLD} state_t;

  state_t        state_q, state_d;
  logic [63:0]   pa_q, pa_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [63:0]   line_data_q, line_data_d;
  logic [3:0]    size_q, size_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [10:0]   addr_count_q, addr_count_d;
  logic          line_write_q, line_write_d;
  logic          gap_q, gap_d;
  logic          err_q, err_d;
  logic          entry_q, entry_d;
  logic          timeout_hit;
  logic          fail;

`ifdef CBU_TIMEOUT_EN
  // Counter sits at zero whenever mem_req is low, so it restarts on each rising edge.
  logic [31:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = mem_req ? tmo_cnt_q + 32'd1 : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) tmo_cnt_q <= 32'd0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end

  assign timeout_hit = mem_req && (tmo_cnt_q == 32'(TIMEOUT_CYCLES));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  assign fail = mem_err || timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pa_q         <= '0;
      wdata_q      <= '0;
      line_data_q  <= '0;
      size_q       <= '0;
      beat_q       <= '0;
      addr_count_q <= '0;
      line_write_q <= 1'b0;
      gap_q        <= 1'b0;
      err_q        <= 1'b0;
      entry_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pa_q         <= pa_d;
      wdata_q      <= wdata_d;
      line_data_q  <= line_data_d;
      size_q       <= size_d;
      beat_q       <= beat_d;
      addr_count_q <= addr_count_d;
      line_write_q <= line_write_d;
      gap_q        <= gap_d;
      err_q        <= err_d;
      entry_q      <= entry_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pa_d         = pa_q;
    wdata_d      = wdata_q;
    line_data_d  = line_data_q;
    size_d       = size_q;
    beat_d       = beat_q;
    addr_count_d = addr_count_q;
    line_write_d = 1'b0;
    gap_d        = gap_q;
    err_d        = err_q;
    entry_d      = entry_q;
    unique case (state_q)
      IDLE: begin
        err_d   = 1'b0;
        entry_d = 1'b0;
        gap_d   = 1'b0;
        beat_d  = '0;
        if (L1_write_through_req || read_line_req || read_req) begin
          pa_d    = pa;
          wdata_d = wt_data;
          size_d  = L1_size;
          if (L1_write_through_req) state_d = WT;
          else if (read_line_req)   state_d = LINE;
          else                      state_d = RD;
        end
      end
      WT, RD: begin
        if (fail) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else if (mem_ack) begin
          state_d = DONE;
          if (state_q == RD) line_data_d = mem_rdata;
        end
      end
      LINE: begin
        // gap_q marks the idle cycle between beats; it also carries the beat's line_write.
        if (gap_q) begin
          gap_d = 1'b0;
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
            entry_d = 1'b1;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end else if (fail) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else if (mem_ack) begin
          gap_d        = 1'b1;
          line_write_d = 1'b1;
          line_data_d  = mem_rdata;
          addr_count_d = 11'(beat_q);
        end
      end
      DONE:    state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req           = 1'b0;
    mem_we            = 1'b0;
    mem_addr          = '0;
    mem_wdata         = '0;
    mem_size          = '0;
    trans_rdy         = 1'b0;
    bus_error         = 1'b0;
    cache_entry_write = 1'b0;
    case (state_q)
      WT: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = pa_q;
        mem_wdata = wdata_q;
        mem_size  = size_q;
      end
      RD: begin
        mem_req  = 1'b1;
        mem_addr = pa_q;
        mem_size = size_q;
      end
      LINE: begin
        mem_req  = !gap_q;
        mem_addr = {pa_q[63:BW+3], beat_q, 3'b000};
        mem_size = 4'b1000;
      end
      DONE: begin
        trans_rdy         = 1'b1;
        bus_error         = err_q;
        cache_entry_write = entry_q && !err_q;
      end
      default: ;
    endcase
  end

  assign line_data  = line_data_q;
  assign addr_count = addr_count_q;
  assign line_write = line_write_q;

endmodule
